alu_seq_param: RTL and testbench

Parametrised, handshaked arithmetic/logic unit executing the 16-entry 4-bit opcode set on WIDTH-bit operands, with registered results, a double-width result path and status flags. Operands and opcode are accepted with a valid/ready handshake. Results are held until the consumer accepts them. Multiply can be built as an iterative shift-add engine, which makes the block multi-cycle. It sits between an operand-issuing controller and a result register file.

---
 rtl/alu_seq_param_if.sv | 26 ++
 rtl/alu_seq_param.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_param.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - operand/result handshake bundle for alu_seq_param
interface alu_seq_param_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             flag_zero;
    logic             flag_carry;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, flag_zero, flag_carry
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, res_lo, res_hi, flag_zero, flag_carry
    );
endinterface

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - handshaked 16-op ALU, optional iterative multiply (ALU_SEQ_ITER_MUL_EN)
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_param_if.slave bus
);
    localparam logic [3:0] op_mul = 4'b1100;

    typedef enum logic [1:0] {
        st_idle,
        st_busy,
        st_done
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   start_busy;
    logic   busy_last;

    logic [WIDTH-1:0]   alu_lo;
    logic [WIDTH-1:0]   alu_hi;
    logic               alu_carry;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [2*WIDTH-1:0] shl_ext;

`ifdef ALU_SEQ_ITER_MUL_EN
    localparam int cw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [cw-1:0] cnt_last = cw'(WIDTH - 1);

    logic [cw-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   step_sum;

    assign start_busy = (bus.opcode == op_mul);
    assign busy_last  = (cnt == cnt_last);
    // One adder: add the multiplicand when the current multiplier bit is set.
    assign step_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
`else
    assign start_busy = 1'b0;
    assign busy_last  = 1'b0;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE can retire and accept in one cycle
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            st_idle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = start_busy ? st_busy : st_done;
                end
            end
            st_busy: begin
                if (busy_last) begin
                    state_nxt = st_done;
                end
            end
            st_done: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_nxt = start_busy ? st_busy : st_done;
                    end else begin
                        state_nxt = st_idle;
                    end
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    // Single-cycle result from the live operands; only sampled on accept
    always_comb begin
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext  = {1'b0, bus.a} - {1'b0, bus.b};
        shl_ext   = {{WIDTH{1'b0}}, bus.a} << bus.b;
        alu_lo    = '0;
        alu_hi    = '0;
        alu_carry = 1'b0;
        case (bus.opcode)
            4'b0000: alu_lo[0] = |bus.a;
            4'b0001: alu_lo[0] = &bus.a;
            4'b0010: alu_lo[0] = ^bus.a;
            4'b0011: alu_lo    = bus.a & bus.b;
            4'b0100: alu_lo    = bus.a | bus.b;
            4'b0101: alu_lo    = bus.a ^ bus.b;
            4'b0110: alu_lo[0] = (bus.a > bus.b);
            4'b0111: alu_lo[0] = (bus.a < bus.b);
            4'b1000: alu_lo[0] = (bus.a == '0);
            4'b1001: alu_lo[0] = (bus.a == bus.b);
            4'b1010: begin
                alu_lo    = sum_ext[WIDTH-1:0];
                alu_hi[0] = sum_ext[WIDTH];
                alu_carry = sum_ext[WIDTH];
            end
            4'b1011: begin
                alu_lo    = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            4'b1100: begin
`ifdef ALU_SEQ_ITER_MUL_EN
                alu_lo = '0;
`else
                {alu_hi, alu_lo} = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif
            end
            4'b1101: alu_lo = bus.a >> bus.b;
            4'b1110: {alu_hi, alu_lo} = shl_ext;
            4'b1111: alu_lo = ~bus.a;
            default: alu_lo = '0;
        endcase
    end

`ifdef ALU_SEQ_ITER_MUL_EN
    // Shift-add engine: product bits shift into acc_lo as multiplier bits leave it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (accept && start_busy) begin
            cnt    <= '0;
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
        end else if (state == st_busy) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_sum[WIDTH:1];
            acc_lo <= {step_sum[0], acc_lo[WIDTH-1:1]};
        end
    end
`endif

    // Result registers: load on single-cycle accept or on the last multiply step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res_lo     <= '0;
            bus.res_hi     <= '0;
            bus.flag_zero  <= 1'b0;
            bus.flag_carry <= 1'b0;
        end else if (accept && !start_busy) begin
            bus.res_lo     <= alu_lo;
            bus.res_hi     <= alu_hi;
            bus.flag_zero  <= (alu_lo == '0);
            bus.flag_carry <= alu_carry;
        end
`ifdef ALU_SEQ_ITER_MUL_EN
        else if (state == st_busy && busy_last) begin
            bus.res_lo     <= {step_sum[0], acc_lo[WIDTH-1:1]};
            bus.res_hi     <= step_sum[WIDTH:1];
            bus.flag_zero  <= ({step_sum[0], acc_lo[WIDTH-1:1]} == '0);
            bus.flag_carry <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - scoreboard bench for alu_seq_param
module tb_alu_seq_param;
    localparam int W = 8;
`ifdef ALU_SEQ_ITER_MUL_EN
    localparam int mul_wait = W;
`else
    localparam int mul_wait = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    alu_seq_param_if #(.WIDTH(W)) bus ();

    alu_seq_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         z;
        logic         c;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    res_t bp_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_acc = 0;
    int   last_acc = 0;
    logic rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic res_t model(input int op, input int a, input int b);
        int   m  = 1 << W;
        int   r  = 0;
        int   lo = 0;
        int   hi = 0;
        int   c  = 0;
        res_t e;
        case (op)
            0:  lo = (a != 0);
            1:  lo = (a == m - 1);
            2:  lo = $countones(a) % 2;
            3:  lo = a & b;
            4:  lo = a | b;
            5:  lo = a ^ b;
            6:  lo = (a > b);
            7:  lo = (a < b);
            8:  lo = (a == 0);
            9:  lo = (a == b);
            10: begin r = a + b; lo = r % m; hi = r / m; c = (r >= m); end
            11: begin lo = (a - b + m) % m; c = (a < b); end
            12: begin r = a * b; lo = r % m; hi = r / m; end
            13: if (b < W) lo = a / (1 << b);
            14: if (b < 2 * W) begin r = (a * (1 << b)) % (m * m); lo = r % m; hi = r / m; end
            default: lo = m - 1 - a;
        endcase
        e.lo = lo[W-1:0];
        e.hi = hi[W-1:0];
        e.z  = (lo == 0);
        e.c  = c[0];
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op; called between edges, returns #1 after its accept edge.
    task automatic issue(input int op, input int a, input int b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op[3:0];
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(op, a, b));
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", int'({bus.res_hi, bus.res_lo, bus.flag_zero, bus.flag_carry}), int'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int t;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = 4'hA;
        bus.a         = 8'hFF;
        bus.b         = 8'h01;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_res", int'({bus.res_hi, bus.res_lo}), 0);
        chk("rst_flags", int'({bus.flag_zero, bus.flag_carry}), 0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(10, 'hFF, 'h01);
        chk("add_valid", int'(bus.out_valid), 1);
        chk("add_lo", int'(bus.res_lo), 'h00);
        chk("add_hi", int'(bus.res_hi), 'h01);
        chk("add_flags", int'({bus.flag_zero, bus.flag_carry}), 3);

        issue(11, 'h05, 'h07);
        chk("sub_lo", int'(bus.res_lo), 'hFE);
        chk("sub_flags", int'({bus.flag_zero, bus.flag_carry}), 1);

        issue(14, 'h81, 4);
        chk("shl_res", int'({bus.res_hi, bus.res_lo}), 'h0810);

        issue(14, 'h81, 16);
        chk("shl16_res", int'({bus.res_hi, bus.res_lo}), 0);

        issue(12, 200, 150);
        for (int i = 0; i < mul_wait; i++) begin
            chk("mul_busy_valid", int'(bus.out_valid), 0);
            chk("mul_busy_ready", int'(bus.in_ready), 0);
            @(posedge clk);
            #1;
        end
        chk("mul_valid", int'(bus.out_valid), 1);
        chk("mul_res", int'({bus.res_hi, bus.res_lo}), 'h7530);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        issue(12, 13, 11);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_busy_valid", int'(bus.out_valid), 0);
        chk("rst_busy_ready", int'(bus.in_ready), 1);
        chk("rst_busy_res", int'({bus.res_hi, bus.res_lo}), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        op = $urandom_range(0, 10);
        t  = $urandom_range(0, 255);
        issue(op, t, 'h5A);
        bp_e = model(op, t, 'h5A);
        bus.in_valid = 1'b1;
        bus.opcode   = 4'hA;
        bus.a        = 8'h3C;
        bus.b        = 8'hD7;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_stable", int'({bus.res_hi, bus.res_lo, bus.flag_zero, bus.flag_carry}), int'(bp_e));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", int'(bus.in_ready), 1);
        exp_q.push_back(model(10, 'h3C, 'hD7));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_next_valid", int'(bus.out_valid), 1);
        chk("bp_next_res", int'({bus.res_hi, bus.res_lo}), 'h0113);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                op = (i + r * 5) % 16;
                t  = (op == 13 || op == 14) ? $urandom_range(0, 18) : $urandom_range(0, 255);
                issue(op, $urandom_range(0, 255), t);
                if (i == 0) first_acc = last_acc;
            end
            chk("stream_cycles", last_acc - first_acc, 15 + mul_wait);
        end

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 15);
            t  = (op == 13 || op == 14) ? $urandom_range(0, 20) : $urandom_range(0, 255);
            issue(op, $urandom_range(0, 255), t);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
